// File: rtl/instr_program_loader.sv
// instr_program_loader: encodes ALU descriptors into RV32I words and streams them,
// through a small FIFO and a backpressured write stage, into instruction memory.
module instr_program_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0,
    parameter int MEM_WORDS  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_imm_sel,
    input  logic              in_last,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              done,
    output logic              mem_full,
    output logic              err
);
    typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [CW-1:0]     DEPTH = CW'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [31:0]       fifo_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]   acc_q, acc_d, words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d, full_q, full_d, err_q, err_d, started_q, started_d;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       enc;
    logic              legal, accept, push, pop, wr_done;

    always_comb begin
        funct3 = (in_op == 3'd2) ? 3'd4 : (in_op == 3'd3) ? 3'd6 : (in_op == 3'd4) ? 3'd7 : 3'd0;
        funct7 = (in_op == 3'd1) ? 7'h20 : 7'h00;
        enc    = in_imm_sel ? {in_imm, in_rs1, funct3, in_rd, 7'b0010011}
                            : {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
        legal  = (in_op <= 3'd4) && !((in_op == 3'd1) && in_imm_sel);
    end

    // in_ready depends only on registered state and clear, never on mem_ready
    assign in_ready = started_q && (state_q == LOAD) && (cnt_q != DEPTH) && !clear;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign wr_done  = we_q && mem_ready;
    assign pop      = (cnt_q != '0) && (!we_q || mem_ready);

    always_comb begin
        state_d   = state_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        acc_d     = acc_q;
        words_d   = words_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        full_d    = full_q;
        err_d     = err_q || (accept && !legal);
        started_d = 1'b1;
        if (push) begin
            fifo_d[wr_ptr_q] = enc;
            wr_ptr_d         = wr_ptr_q + PW'(1);
            acc_d            = acc_q + (ADDR_W+1)'(1);
        end
        if (wr_done) begin
            addr_d  = addr_q + ADDR_W'(1);
            words_d = words_q + (ADDR_W+1)'(1);
        end
        if (pop) begin
            we_d     = 1'b1;
            wdata_d  = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (wr_done) begin
            we_d = 1'b0;
        end
        case (state_q)
            LOAD: begin
                if (push && (acc_q + (ADDR_W+1)'(1) == LIMIT)) begin
                    full_d  = 1'b1;
                    state_d = DRAIN;
                end else if (accept && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = ((cnt_q == '0) && (!we_q || mem_ready)) ? DONE : DRAIN;
            default: state_d = DONE;
        endcase
        if (clear) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            acc_d    = '0;
            words_d  = '0;
            addr_d   = BASE;
            wdata_d  = '0;
            we_d     = 1'b0;
            full_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            fifo_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            words_q   <= '0;
            addr_q    <= BASE;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            full_q    <= full_d;
            err_q     <= err_d;
            started_q <= started_d;
        end
    end

    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign words_written = words_q;
    assign done          = (state_q == DONE);
    assign mem_full      = full_q;
    assign err           = err_q;
endmodule

// File: tb/tb_instr_program_loader.sv
// tb_instr_program_loader: randomized bench with a queue-based reference model;
// a second instance with MEM_WORDS=4 shares the stimulus to exercise the session limit.
module tb_instr_program_loader;
    localparam int LIM = 4;

    logic        clk, rst_n, clear, in_valid, in_imm_sel, in_last, mem_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [11:0] in_imm;
    logic        in_ready, mem_we, done, mem_full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words_written;
    logic        in_ready_l, mem_we_l, done_l, mem_full_l, err_l;
    logic [7:0]  mem_addr_l;
    logic [31:0] mem_wdata_l;
    logic [8:0]  words_written_l;

    instr_program_loader u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_imm_sel(in_imm_sel), .in_last(in_last), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .words_written(words_written), .done(done), .mem_full(mem_full), .err(err)
    );

    instr_program_loader #(.MEM_WORDS(LIM)) u_lim (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_op(in_op), .in_imm_sel(in_imm_sel), .in_last(in_last), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we_l),
        .mem_ready(mem_ready), .mem_addr(mem_addr_l), .mem_wdata(mem_wdata_l),
        .words_written(words_written_l), .done(done_l), .mem_full(mem_full_l), .err(err_l)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    logic [2:0]  d_op     [16];
    logic        d_sel    [16];
    logic        d_last   [16];
    logic [4:0]  d_rd     [16];
    logic [4:0]  d_rs1    [16];
    logic [4:0]  d_rs2    [16];
    logic [11:0] d_imm    [16];

    logic [31:0] exp_m[$];
    logic [31:0] exp_l[$];
    logic [31:0] log_q[$];
    logic [7:0]  exp_addr_m, exp_addr_l;
    int          exp_cnt_m, exp_cnt_l;
    logic        err_m_e, err_l_e, full_l_e, lim_open;
    logic        rnd_rdy, force_rdy;

    function automatic logic [31:0] encode(input int i);
        int f3 [5];
        int f7;
        f3 = '{0, 0, 4, 6, 7};
        f7 = (d_op[i] == 3'd1) ? 32 : 0;
        if (d_sel[i])
            return (32'(d_imm[i]) << 20) | (32'(d_rs1[i]) << 15) | (32'(f3[d_op[i]]) << 12)
                 | (32'(d_rd[i]) << 7) | 32'h13;
        return (32'(f7) << 25) | (32'(d_rs2[i]) << 20) | (32'(d_rs1[i]) << 15)
             | (32'(f3[d_op[i]]) << 12) | (32'(d_rd[i]) << 7) | 32'h33;
    endfunction

    task automatic model_reset();
        exp_m.delete();
        exp_l.delete();
        log_q.delete();
        exp_addr_m = 8'd0;
        exp_addr_l = 8'd0;
        exp_cnt_m  = 0;
        exp_cnt_l  = 0;
        err_m_e    = 1'b0;
        err_l_e    = 1'b0;
        full_l_e   = 1'b0;
        lim_open   = 1'b1;
    endtask

    task automatic model_accept(input int i);
        logic legal;
        legal = (d_op[i] <= 3'd4) && !(d_op[i] == 3'd1 && d_sel[i]);
        if (legal) begin
            exp_m.push_back(encode(i));
            exp_cnt_m++;
        end else err_m_e = 1'b1;
        if (lim_open) begin
            if (legal) begin
                exp_l.push_back(encode(i));
                exp_cnt_l++;
                if (exp_cnt_l == LIM) begin
                    lim_open = 1'b0;
                    full_l_e = 1'b1;
                end
            end else err_l_e = 1'b1;
            if (d_last[i]) lim_open = 1'b0;
        end
    endtask

    task automatic set_desc(input int i, input int op, input int sel, input int rd,
                            input int rs1, input int rs2, input int imm, input int last);
        d_op[i]   = 3'(op);
        d_sel[i]  = 1'(sel);
        d_rd[i]   = 5'(rd);
        d_rs1[i]  = 5'(rs1);
        d_rs2[i]  = 5'(rs2);
        d_imm[i]  = 12'(imm);
        d_last[i] = 1'(last);
    endtask

    task automatic rand_desc(input int i, input int last);
        int op;
        op = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        set_desc(i, op, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 4095), last);
    endtask

    // Called just after a rising edge; offers descriptors first.. back-to-back.
    task automatic run_descs(input int first, input int n, input int budget, output int nacc);
        nacc = 0;
        for (int c = 0; c < budget && nacc < n; c++) begin
            in_valid   = 1'b1;
            in_op      = d_op[first+nacc];
            in_imm_sel = d_sel[first+nacc];
            in_last    = d_last[first+nacc];
            in_rd      = d_rd[first+nacc];
            in_rs1     = d_rs1[first+nacc];
            in_rs2     = d_rs2[first+nacc];
            in_imm     = d_imm[first+nacc];
            @(negedge clk);
            if (in_ready) begin
                model_accept(first + nacc);
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_session();
        int c;
        c = 0;
        while (!done && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("done_m", done, 1);
        check("words_m", words_written, exp_cnt_m);
        check("drained_m", exp_m.size(), 0);
        check("err_m", err, err_m_e);
        check("full_m", mem_full, 0);
        check("rdy_done_m", in_ready, 0);
        c = 0;
        while (!done_l && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("done_l", done_l, 1);
        check("words_l", words_written_l, exp_cnt_l);
        check("drained_l", exp_l.size(), 0);
        check("err_l", err_l, err_l_e);
        check("full_l", mem_full_l, full_l_e);
        check("rdy_done_l", in_ready_l, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_words"}, words_written, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_full"}, mem_full, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_we_l"}, mem_we_l, 0);
        check({tag, "_words_l"}, words_written_l, 0);
        check({tag, "_done_l"}, done_l, 0);
        check({tag, "_full_l"}, mem_full_l, 0);
        check({tag, "_err_l"}, err_l, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_idle("clear");
        model_reset();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        end
    end

    logic        stall_m, stall_l;
    logic [7:0]  st_addr_m, st_addr_l;
    logic [31:0] st_data_m, st_data_l;

    initial begin
        stall_m = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && !clear) begin
                if (stall_m && mem_we) begin
                    check("stall_addr_m", mem_addr, st_addr_m);
                    check("stall_data_m", mem_wdata, st_data_m);
                end
                stall_m   = mem_we && !mem_ready;
                st_addr_m = mem_addr;
                st_data_m = mem_wdata;
                if (mem_we) begin
                    check("we_has_word_m", exp_m.size() != 0, 1);
                    if (mem_ready && exp_m.size() != 0) begin
                        check("wr_addr_m", mem_addr, exp_addr_m);
                        check("wr_data_m", mem_wdata, exp_m.pop_front());
                        log_q.push_back(mem_wdata);
                        exp_addr_m++;
                    end
                end
            end else stall_m = 1'b0;
        end
    end

    initial begin
        stall_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && !clear) begin
                if (stall_l && mem_we_l) begin
                    check("stall_addr_l", mem_addr_l, st_addr_l);
                    check("stall_data_l", mem_wdata_l, st_data_l);
                end
                stall_l   = mem_we_l && !mem_ready;
                st_addr_l = mem_addr_l;
                st_data_l = mem_wdata_l;
                if (mem_we_l) begin
                    check("we_has_word_l", exp_l.size() != 0, 1);
                    if (mem_ready && exp_l.size() != 0) begin
                        check("wr_addr_l", mem_addr_l, exp_addr_l);
                        check("wr_data_l", mem_wdata_l, exp_l.pop_front());
                        exp_addr_l++;
                    end
                end
            end else stall_l = 1'b0;
        end
    end

    initial begin
        int nacc, n;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_op = '0; in_imm_sel = 1'b0;
        in_last = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        rnd_rdy = 1'b0; force_rdy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_rdy", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", in_ready, 1);

        // single ADD: exact latency to mem_we and to done
        set_desc(0, 0, 0, 1, 2, 3, 0, 1);
        run_descs(0, 1, 10, nacc);
        check("t1_acc", nacc, 1);
        check("t1_we_early", mem_we, 0);
        @(posedge clk);
        #1;
        check("t1_we", mem_we, 1);
        check("t1_addr", mem_addr, 0);
        check("t1_data", mem_wdata, 32'h003100B3);
        @(posedge clk);
        #1;
        check("t1_done", done, 1);
        check("t1_words", words_written, 1);
        finish_session();
        do_clear();

        // SUB R-type then XOR I-type
        set_desc(0, 1, 0, 5, 6, 7, 0, 0);
        set_desc(1, 2, 1, 1, 1, 0, 12'h0FF, 1);
        run_descs(0, 2, 20, nacc);
        finish_session();
        check("t2_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t2_w0", log_q[0], 32'h407302B3);
            check("t2_w1", log_q[1], 32'h0FF0C093);
        end
        do_clear();

        // stalled memory: FIFO plus write stage absorb five descriptors
        force_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_desc(i, i == 5);
            d_op[i] = 3'(i % 5);
            d_sel[i] = 1'b0;
        end
        run_descs(0, 6, 8, nacc);
        check("t3_acc", nacc, 5);
        check("t3_rdy", in_ready, 0);
        check("t3_we", mem_we, 1);
        check("t3_words", words_written, 0);
        force_rdy = 1'b1;
        run_descs(5, 1, 20, nacc);
        check("t3_acc_last", nacc, 1);
        finish_session();
        check("t3_count", log_q.size(), 6);
        do_clear();

        // illegal descriptors only
        set_desc(0, 6, 0, 3, 4, 5, 0, 0);
        set_desc(1, 1, 1, 3, 4, 5, 12'h123, 1);
        run_descs(0, 2, 10, nacc);
        check("t4_acc", nacc, 2);
        check("t4_we", mem_we, 0);
        finish_session();
        do_clear();

        // six descriptors: limited instance stops at four
        rnd_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_desc(i, i == 5);
            d_op[i] = 3'(i % 5);
            d_sel[i] = 1'b0;
        end
        run_descs(0, 6, 100, nacc);
        check("t5_acc", nacc, 6);
        finish_session();
        check("t5_full_l", mem_full_l, 1);
        check("t5_words_l", words_written_l, LIM);
        do_clear();

        // randomized sessions
        for (int s = 0; s < 15; s++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) rand_desc(i, i == n - 1);
            run_descs(0, n, 300, nacc);
            check("rnd_acc", nacc, n);
            finish_session();
            do_clear();
        end

        // asynchronous reset while a write is stalled
        rnd_rdy = 1'b0;
        force_rdy = 1'b0;
        set_desc(0, 3, 0, 9, 10, 11, 0, 0);
        set_desc(1, 4, 1, 12, 13, 0, 12'hABC, 0);
        run_descs(0, 2, 10, nacc);
        @(posedge clk);
        #1;
        check("t7_we_pre", mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_we", mem_we, 0);
        check("t7_done", done, 0);
        check("t7_words", words_written, 0);
        check("t7_rdy", in_ready, 0);
        check("t7_we_l", mem_we_l, 0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        force_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t7_fifo_empty", mem_we, 0);
        check("t7_fifo_empty_l", mem_we_l, 0);
        check("t7_words_after", words_written, 0);
        check("t7_done_after", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_program_loader.md
Name: instr_program_loader

Overview:
- Inverse of the pipeline's instruction decoder: takes field-level ALU instruction descriptors, encodes them into 32-bit RV32I words, and streams them into instruction memory at consecutive word addresses.
- Sits between the testbench/boot controller and the instruction-memory write port.
- Input descriptors are buffered in a small FIFO; memory writes are backpressured by mem_ready.

Parameters:
ADDR_W, 8, instruction-memory word-address width
FIFO_DEPTH, 4, encoded-word FIFO entries (power of 2, >=2)
BASE_ADDR, 0, first word address written after reset/clear
MEM_WORDS, 256, maximum words accepted per load session (<= 2^ADDR_W)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous session restart
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid&in_ready
in_op  input  3  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5-7 illegal
in_imm_sel  input  1  1 = I-type (immediate operand), 0 = R-type
in_last  input  1  final descriptor of the session
in_rd, in_rs1, in_rs2  input  5 each  register fields
in_imm  input  12  I-type immediate
mem_we  output  1  write request
mem_ready  input  1  memory takes write when mem_we&mem_ready
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  encoded instruction
words_written  output  ADDR_W+1  completed writes this session
done  output  1  session complete, all words written
mem_full  output  1  MEM_WORDS accepted, session force-terminated
err  output  1  sticky: illegal descriptor seen

Behaviour:
- Reset (rst_n low, asynchronous): state LOAD, FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, done=0, mem_full=0, err=0, in_ready=0 until first edge after release.
- Encoding (combinational, at input):
  - R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - I-type: {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - funct3/funct7: ADD 0/0x00, SUB 0/0x20, XOR 4/0x00, OR 6/0x00, AND 7/0x00.
  - opcode bit 5 equals !in_imm_sel.
- Illegal descriptors: in_op>=5, or SUB with in_imm_sel=1.
  - Still consumed (handshake completes); nothing pushed; err set sticky.
  - in_last on an illegal descriptor still ends the session.
- in_ready is registered-state only (no combinational path from mem_ready): in_ready = (state==LOAD) && !fifo_full && !clear.
- Accepted count reaching MEM_WORDS: mem_full=1, state goes to DRAIN on the same edge.
- FSM:
  - LOAD: accept descriptors. An accepted in_last, or the MEM_WORDS limit, moves to DRAIN.
  - DRAIN: in_ready=0; write out remaining FIFO words. FIFO empty and no write pending moves to DONE.
  - DONE: done=1, in_ready=0; hold until clear.
- Write stage: output register holding mem_we/mem_addr/mem_wdata.
  - Loads the FIFO head when (!mem_we || mem_ready) and FIFO non-empty.
  - mem_we is held, with address/data stable, while mem_ready=0.
  - Each completed write increments mem_addr (modulo 2^ADDR_W) and words_written.
- Latency: a descriptor accepted at edge N into an empty FIFO with an idle write stage drives mem_we=1 after edge N+1.
- FIFO: simultaneous push and pop is legal at any occupancy below full. Full means no push (in_ready=0). Empty means no pop.
- clear (highest priority after reset): same values as reset in one edge. A pending mem_we is dropped without completion.
- done and mem_full are both set when the limit-triggered drain finishes.

Test Plan:
- Reset, then R-type ADD rd=1 rs1=2 rs2=3, in_last=1, mem_ready=1 -> mem_wdata=0x003100B3 at addr 0 one cycle after accept; done=1 two cycles later; words_written=1.
- SUB rd=5 rs1=6 rs2=7 then I-type XOR rd=1 rs1=1 imm=0x0FF -> words 0x407302B3, 0x0FF0C093 at addrs 0,1.
- mem_ready held 0 for 6 cycles, 6 back-to-back descriptors -> in_ready drops after 4 accepted plus 1 in the write stage; addr/data stable while stalled; all 6 written in order once released.
- in_op=6, then SUB with in_imm_sel=1 -> both consumed, err=1, no mem_we, words_written unchanged.
- MEM_WORDS=4 build with 6 descriptors offered -> 4 accepted, mem_full=1, in_ready=0, done after the 4th write. clear -> all outputs at reset values, next write at BASE_ADDR.
- rst_n asserted mid-stall with mem_we=1 -> mem_we=0 immediately (asynchronous), FIFO empty, done=0.
